// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//
// Purpose:
//   HH:MM:SS.CC stopwatch counter placed between the centisecond tick
//   generator and the 7-segment display mux. Counts up or down in packed BCD,
//   with a run/pause/clear state machine, validated parallel load, a tick
//   prescaler, a configurable hour modulus and an optional lap hold.
//
// Parameters:
//   HOUR_WRAP  hour modulus, 1..100; hours count 0..HOUR_WRAP-1
//   TICK_DIV   tick_i pulses per centisecond advance, >= 1
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   tick_i        single-cycle tick pulse
//   start_stop_i  pulse, toggles run/pause (starts from IDLE)
//   clear_i       pulse, zeroes the counter and returns to IDLE
//   dir_i         0 = up, 1 = down; latched when leaving IDLE
//   load_i        pulse, load load_value_i (IDLE or PAUSE only)
//   load_value_i  packed BCD, [31:28]=HOUR1 ... [3:0]=CSEG0
//   lap_i         pulse, capture/release lap hold (STOPWATCH_LAP_EN only)
//   digits_o      packed BCD display value
//   running_o     high in RUN
//   wrap_o        one-cycle pulse on up-count rollover
//   expired_o     one-cycle pulse when a down-count reaches zero
//   load_err_o    one-cycle pulse when a load is rejected
//   lap_active_o  high while a lap value is held
//
// Optional feature macro: STOPWATCH_LAP_EN (adds lap_i and the lap hold).
// -----------------------------------------------------------------------------
module stopwatch_core #(
    parameter int HOUR_WRAP = 24,
    parameter int TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic        start_stop_i,
    input  logic        clear_i,
    input  logic        dir_i,
    input  logic        load_i,
    input  logic [31:0] load_value_i,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap_i,
`endif
    output logic [31:0] digits_o,
    output logic        running_o,
    output logic        wrap_o,
    output logic        expired_o,
    output logic        load_err_o,
    output logic        lap_active_o
);

    localparam int              PW         = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]      HOUR_MAX   = {4'((HOUR_WRAP - 1) / 10), 4'((HOUR_WRAP - 1) % 10)};
    localparam logic [7:0]      HOUR_LIMIT = 8'(HOUR_WRAP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    state_t        state, state_n;
    logic [31:0]   count, count_n;
    logic [PW-1:0] presc, presc_n;
    logic          dir_q, dir_n;
    logic          wrap_n, exp_n, err_n;
    logic [31:0]   stepped;
    logic          tick_ok;
    logic          load_ok;
`ifdef STOPWATCH_LAP_EN
    logic [31:0]   lap_q, lap_n;
    logic          hold_q, hold_n;
`endif

    // SEG1 and MIN1 are the base-6 digits; everything below hours is base 10.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

    // One centisecond step up or down. Each digit moves only when every lower
    // digit sits at its terminal value (max going up, zero going down).
    function automatic logic [31:0] step_count(input logic [31:0] v, input logic down);
        logic [31:0] r;
        logic        en;
        logic [3:0]  d;
        logic [7:0]  h;
        r  = v;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = v[4*i +: 4];
            if (en) begin
                if (down) r[4*i +: 4] = (d == 4'd0) ? digit_max(i) : d - 4'd1;
                else      r[4*i +: 4] = (d == digit_max(i)) ? 4'd0 : d + 4'd1;
            end
            en = en & (down ? (d == 4'd0) : (d == digit_max(i)));
        end
        h = v[31:24];
        if (en) begin
            if (down) begin
                if (h == 8'd0)              r[31:24] = HOUR_MAX;
                else if (h[3:0] == 4'd0)    r[31:24] = {h[7:4] - 4'd1, 4'd9};
                else                        r[31:24] = {h[7:4], h[3:0] - 4'd1};
            end else begin
                if (h == HOUR_MAX)          r[31:24] = 8'd0;
                else if (h[3:0] == 4'd9)    r[31:24] = {h[7:4] + 4'd1, 4'd0};
                else                        r[31:24] = {h[7:4], h[3:0] + 4'd1};
            end
        end
        return r;
    endfunction

    function automatic logic load_valid(input logic [31:0] v);
        logic       ok;
        logic [7:0] hours;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        if (v[15:12] > 4'd5) ok = 1'b0;
        if (v[23:20] > 4'd5) ok = 1'b0;
        hours = {4'd0, v[31:28]} * 8'd10 + {4'd0, v[27:24]};
        if (hours >= HOUR_LIMIT) ok = 1'b0;
        return ok;
    endfunction

    assign stepped = step_count(count, dir_q);
    assign load_ok = load_valid(load_value_i);

    // A tick coinciding with start/stop or clear is dropped so the state
    // change is the only thing that happens that cycle.
    assign tick_ok = (state == RUN) && tick_i && !start_stop_i && !clear_i;

    // Next-state and datapath: one control action chosen by priority
    // (clear > load > start/stop > lap), then the prescaled advance.
    always_comb begin
        state_n = state;
        count_n = count;
        presc_n = presc;
        dir_n   = dir_q;
        wrap_n  = 1'b0;
        exp_n   = 1'b0;
        err_n   = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_n   = lap_q;
        hold_n  = hold_q;
`endif

        if (clear_i) begin
            state_n = IDLE;
            count_n = 32'd0;
            presc_n = '0;
`ifdef STOPWATCH_LAP_EN
            lap_n   = 32'd0;
            hold_n  = 1'b0;
`endif
        end else if (load_i) begin
            if (state == IDLE || state == PAUSE) begin
                if (load_ok) begin
                    count_n = load_value_i;
                    presc_n = '0;
                end else begin
                    err_n = 1'b1;
                end
            end
        end else if (start_stop_i) begin
            case (state)
                IDLE: begin
                    // Starting a down-count from zero would expire at once.
                    if (!(dir_i && count == 32'd0)) begin
                        state_n = RUN;
                        dir_n   = dir_i;
                        presc_n = '0;
                    end
                end
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = state;
            endcase
`ifdef STOPWATCH_LAP_EN
        end else if (lap_i) begin
            if (hold_q) begin
                hold_n = 1'b0;
            end else if (state == RUN || state == PAUSE) begin
                lap_n  = count;
                hold_n = 1'b1;
            end
`endif
        end

        if (tick_ok) begin
            if (presc == PRESC_LAST) begin
                presc_n = '0;
                count_n = stepped;
                if (stepped == 32'd0) begin
                    if (dir_q) begin
                        state_n = EXPIRED;
                        exp_n   = 1'b1;
                    end else begin
                        wrap_n  = 1'b1;
                    end
                end
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= 32'd0;
            presc      <= '0;
            dir_q      <= 1'b0;
            wrap_o     <= 1'b0;
            expired_o  <= 1'b0;
            load_err_o <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q      <= 32'd0;
            hold_q     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            count      <= count_n;
            presc      <= presc_n;
            dir_q      <= dir_n;
            wrap_o     <= wrap_n;
            expired_o  <= exp_n;
            load_err_o <= err_n;
`ifdef STOPWATCH_LAP_EN
            lap_q      <= lap_n;
            hold_q     <= hold_n;
`endif
        end
    end

    assign running_o = (state == RUN);

`ifdef STOPWATCH_LAP_EN
    assign digits_o     = hold_q ? lap_q : count;
    assign lap_active_o = hold_q;
`else
    assign digits_o     = count;
    assign lap_active_o = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
//
// Purpose:
//   Self-checking bench for stopwatch_core. Two instances share the inputs:
//   dut_a (HOUR_WRAP=24, TICK_DIV=1) and dut_b (HOUR_WRAP=12, TICK_DIV=4).
//   A reference model keeps the time as an integer number of centiseconds and
//   is compared with both instances every cycle; a vector table and a few
//   hand-written sequences add fixed expectations.
//
// Ports: none (top-level bench). Honours STOPWATCH_LAP_EN.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, tick_i, start_stop_i, clear_i, dir_i, load_i, lap_req;
    logic [31:0] load_value_i;

    logic [31:0] dig_a, dig_b;
    logic        run_a, run_b, wrap_a, wrap_b, exp_a, exp_b, err_a, err_b, lap_a, lap_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.HOUR_WRAP(24), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .start_stop_i(start_stop_i),
        .clear_i(clear_i), .dir_i(dir_i), .load_i(load_i), .load_value_i(load_value_i),
`ifdef STOPWATCH_LAP_EN
        .lap_i(lap_req),
`endif
        .digits_o(dig_a), .running_o(run_a), .wrap_o(wrap_a), .expired_o(exp_a),
        .load_err_o(err_a), .lap_active_o(lap_a)
    );

    stopwatch_core #(.HOUR_WRAP(12), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .start_stop_i(start_stop_i),
        .clear_i(clear_i), .dir_i(dir_i), .load_i(load_i), .load_value_i(load_value_i),
`ifdef STOPWATCH_LAP_EN
        .lap_i(lap_req),
`endif
        .digits_o(dig_b), .running_o(run_b), .wrap_o(wrap_b), .expired_o(exp_b),
        .load_err_o(err_b), .lap_active_o(lap_b)
    );

    // ---------------- reference model (centiseconds as an integer) ----------
    // state: 0 idle, 1 run, 2 pause, 3 expired
    int m_state[2], m_t[2], m_pre[2], m_lap[2];
    bit m_dir[2], m_hold[2], m_wrap[2], m_exp[2], m_err[2];

    function automatic int hw_of(int k);
        return (k == 0) ? 24 : 12;
    endfunction

    function automatic int td_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int bcd_to_cs(logic [31:0] v);
        int h, m, s, c;
        h = int'(v[31:28]) * 10 + int'(v[27:24]);
        m = int'(v[23:20]) * 10 + int'(v[19:16]);
        s = int'(v[15:12]) * 10 + int'(v[11:8]);
        c = int'(v[7:4]) * 10 + int'(v[3:0]);
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    function automatic logic [31:0] cs_to_bcd(int t);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic bit bcd_valid(logic [31:0] v, int k);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (int'(v[4*i +: 4]) > 9) ok = 1'b0;
        if (int'(v[15:12]) > 5) ok = 1'b0;
        if (int'(v[23:20]) > 5) ok = 1'b0;
        if (int'(v[31:28]) * 10 + int'(v[27:24]) >= hw_of(k)) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n;
            bit adv;
            n = hw_of(k) * 360000;
            if (!rst_n) begin
                m_state[k] = 0; m_t[k] = 0; m_pre[k] = 0; m_lap[k] = 0;
                m_dir[k] = 0; m_hold[k] = 0; m_wrap[k] = 0; m_exp[k] = 0; m_err[k] = 0;
            end else begin
                adv = (m_state[k] == 1) && tick_i && !start_stop_i && !clear_i;
                m_wrap[k] = 0; m_exp[k] = 0; m_err[k] = 0;
                if (clear_i) begin
                    m_state[k] = 0; m_t[k] = 0; m_pre[k] = 0; m_lap[k] = 0; m_hold[k] = 0;
                end else if (load_i) begin
                    if (m_state[k] == 0 || m_state[k] == 2) begin
                        if (bcd_valid(load_value_i, k)) begin
                            m_t[k] = bcd_to_cs(load_value_i);
                            m_pre[k] = 0;
                        end else begin
                            m_err[k] = 1;
                        end
                    end
                end else if (start_stop_i) begin
                    if (m_state[k] == 0) begin
                        if (!(dir_i && m_t[k] == 0)) begin
                            m_state[k] = 1; m_dir[k] = dir_i; m_pre[k] = 0;
                        end
                    end else if (m_state[k] == 1) m_state[k] = 2;
                    else if (m_state[k] == 2) m_state[k] = 1;
                end else if (LAP_EN && lap_req) begin
                    if (m_hold[k]) m_hold[k] = 0;
                    else if (m_state[k] == 1 || m_state[k] == 2) begin
                        m_lap[k] = m_t[k]; m_hold[k] = 1;
                    end
                end
                if (adv) begin
                    if (m_pre[k] == td_of(k) - 1) begin
                        m_pre[k] = 0;
                        if (!m_dir[k]) begin
                            m_t[k] = (m_t[k] + 1) % n;
                            if (m_t[k] == 0) m_wrap[k] = 1;
                        end else begin
                            m_t[k] = (m_t[k] == 0) ? n - 1 : m_t[k] - 1;
                            if (m_t[k] == 0) begin
                                m_exp[k] = 1; m_state[k] = 3;
                            end
                        end
                    end else begin
                        m_pre[k] = m_pre[k] + 1;
                    end
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------------------------------
    task automatic check_val(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Compare both instances with the model after each edge.
    task automatic check_output();
        logic [31:0] exp_dig;
        for (int k = 0; k < 2; k++) begin
            exp_dig = m_hold[k] ? cs_to_bcd(m_lap[k]) : cs_to_bcd(m_t[k]);
            if (k == 0) begin
                check_val("model.a.digits",  dig_a, exp_dig);
                check_val("model.a.running", {31'd0, run_a},  {31'd0, m_state[0] == 1});
                check_val("model.a.wrap",    {31'd0, wrap_a}, {31'd0, m_wrap[0]});
                check_val("model.a.expired", {31'd0, exp_a},  {31'd0, m_exp[0]});
                check_val("model.a.loaderr", {31'd0, err_a},  {31'd0, m_err[0]});
                check_val("model.a.lap",     {31'd0, lap_a},  {31'd0, m_hold[0]});
            end else begin
                check_val("model.b.digits",  dig_b, exp_dig);
                check_val("model.b.running", {31'd0, run_b},  {31'd0, m_state[1] == 1});
                check_val("model.b.wrap",    {31'd0, wrap_b}, {31'd0, m_wrap[1]});
                check_val("model.b.expired", {31'd0, exp_b},  {31'd0, m_exp[1]});
                check_val("model.b.loaderr", {31'd0, err_b},  {31'd0, m_err[1]});
                check_val("model.b.lap",     {31'd0, lap_b},  {31'd0, m_hold[1]});
            end
        end
    endtask

    task automatic check_a(string name, logic [31:0] dg, logic r, logic w, logic e, logic er);
        check_val({name, ".digits"},  dig_a, dg);
        check_val({name, ".running"}, {31'd0, run_a},  {31'd0, r});
        check_val({name, ".wrap"},    {31'd0, wrap_a}, {31'd0, w});
        check_val({name, ".expired"}, {31'd0, exp_a},  {31'd0, e});
        check_val({name, ".loaderr"}, {31'd0, err_a},  {31'd0, er});
    endtask

    // Drive one cycle of inputs, step the model on the edge, check 1 ns later.
    task automatic apply_stimulus(logic r, logic c, logic l, logic s, logic t, logic d,
                                  logic [31:0] v, logic lp);
        rst_n = r; clear_i = c; load_i = l; start_stop_i = s; tick_i = t; dir_i = d;
        load_value_i = v; lap_req = lp;
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic idle_cycle();
        apply_stimulus(1, 0, 0, 0, 0, 0, 32'd0, 0);
    endtask

    task automatic tick_cycle();
        apply_stimulus(1, 0, 0, 0, 1, 0, 32'd0, 0);
    endtask

    // ---------------- vector table ---------------------------------------------
    typedef struct {
        logic        r, c, l, s, t, d;
        logic [31:0] v;
        logic [31:0] e_dig;
        logic        e_run, e_wrap, e_exp, e_err;
    } vec_t;

    function automatic vec_t mk(logic r, logic c, logic l, logic s, logic t, logic d,
                                logic [31:0] v, logic [31:0] ed,
                                logic er, logic ew, logic ee, logic eerr);
        vec_t x;
        x.r = r; x.c = c; x.l = l; x.s = s; x.t = t; x.d = d; x.v = v;
        x.e_dig = ed; x.e_run = er; x.e_wrap = ew; x.e_exp = ee; x.e_err = eerr;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] lv;
        rst_n = 0; tick_i = 0; start_stop_i = 0; clear_i = 0; dir_i = 0;
        load_i = 0; lap_req = 0; load_value_i = 32'd0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_t[k] = 0; m_pre[k] = 0; m_lap[k] = 0;
            m_dir[k] = 0; m_hold[k] = 0; m_wrap[k] = 0; m_exp[k] = 0; m_err[k] = 0;
        end

        //             r  c  l  s  t  d  load          digits(A)   run wr ex err
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 32'h23595998, 32'h23595998, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0,        32'h23595998, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,        32'h23595999, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,        32'h00000000, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h00000000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,        32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 32'h12610000, 32'h00000000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 32'h24000000, 32'h00000000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 32'h09300000, 32'h09300000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h09300000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 32'h0,        32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 32'h0,        32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0,        32'h00000000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 32'h00001111, 32'h00000001, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,        32'h00000000, 0, 0, 0, 0));

        $display("[TB] vector table: %0d entries", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].s, vecs[i].t, vecs[i].d,
                           vecs[i].v, 0);
            check_a($sformatf("vec%0d", i), vecs[i].e_dig, vecs[i].e_run,
                    vecs[i].e_wrap, vecs[i].e_exp, vecs[i].e_err);
        end

        // Prescaler on dut_b (TICK_DIV=4): 10 ticks -> 2 advances, pause keeps it.
        $display("[TB] prescaler sequence");
        apply_stimulus(1, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int i = 0; i < 10; i++) tick_cycle();
        check_val("t2.b_after10", dig_b, 32'h00000002);
        check_val("t2.a_after10", dig_a, 32'h00000010);
        apply_stimulus(1, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) tick_cycle();
        check_val("t2.b_paused", dig_b, 32'h00000002);
        check_val("t2.b_paused_run", {31'd0, run_b}, 32'd0);
        apply_stimulus(1, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int i = 0; i < 2; i++) tick_cycle();
        check_val("t2.b_resumed", dig_b, 32'h00000003);
        check_val("t2.a_resumed", dig_a, 32'h00000012);
        apply_stimulus(1, 1, 0, 0, 0, 0, 32'd0, 0);

        // Down-count to expiry on dut_a, then EXPIRED ignores start/stop and load.
        $display("[TB] expiry sequence");
        apply_stimulus(1, 0, 1, 0, 0, 0, 32'h00000100, 0);
        apply_stimulus(1, 0, 0, 1, 0, 1, 32'd0, 0);
        for (int i = 1; i <= 100; i++) begin
            tick_cycle();
            if (i == 99)  check_a("t3.tick99", 32'h00000001, 1, 0, 0, 0);
            if (i == 100) check_a("t3.expire", 32'h00000000, 0, 0, 1, 0);
        end
        idle_cycle();
        check_a("t3.after", 32'h0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 1, 1, 0, 32'd0, 0);
        check_a("t3.ignore_ss", 32'h0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 1, 0, 0, 0, 32'h00001234, 0);
        check_a("t3.ignore_ld", 32'h0, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 32'd0, 0);
        apply_stimulus(1, 0, 0, 1, 0, 0, 32'd0, 0);
        check_a("t3.idle_restart", 32'h0, 1, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 32'd0, 0);

        // Reset in the middle of a run.
        $display("[TB] mid-run reset sequence");
        apply_stimulus(1, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int i = 0; i < 7; i++) tick_cycle();
        check_a("t5.running", 32'h00000007, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 1, 0, 32'd0, 0);
        check_a("t5.reset", 32'h0, 0, 0, 0, 0);
        check_val("t5.b_digits", dig_b, 32'h0);
        check_val("t5.b_running", {31'd0, run_b}, 32'd0);
        idle_cycle();

`ifdef STOPWATCH_LAP_EN
        // Lap hold freezes the display while the count continues underneath.
        $display("[TB] lap sequence");
        apply_stimulus(1, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int i = 0; i < 500; i++) tick_cycle();
        check_val("t6.at500", dig_a, 32'h00000500);
        apply_stimulus(1, 0, 0, 0, 0, 0, 32'd0, 1);
        check_val("t6.captured", dig_a, 32'h00000500);
        check_val("t6.active", {31'd0, lap_a}, 32'd1);
        for (int i = 0; i < 50; i++) tick_cycle();
        check_val("t6.held", dig_a, 32'h00000500);
        apply_stimulus(1, 0, 0, 0, 0, 0, 32'd0, 1);
        check_val("t6.released", dig_a, 32'h00000550);
        check_val("t6.inactive", {31'd0, lap_a}, 32'd0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 32'd0, 0);
`endif

        // Randomised traffic, model-checked every cycle.
        $display("[TB] random phase");
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 5))
                0: lv = 32'h23595990;
                1: lv = 32'h11595990;
                2: lv = 32'h00000003;
                3: lv = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                4: lv = $urandom;
                default: lv = 32'd0;
            endcase
            apply_stimulus($urandom_range(0, 999) >= 3,
                           $urandom_range(0, 99) < 1,
                           $urandom_range(0, 99) < 4,
                           $urandom_range(0, 99) < 4,
                           $urandom_range(0, 99) < 60,
                           1'($urandom_range(0, 1)),
                           lv,
                           $urandom_range(0, 99) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Parametrised successor to the fixed 8-digit cascaded BCD time counter. Output format is HH:MM:SS.CC.
- Adds count-up/count-down modes, a run/pause/clear state machine, parallel BCD load with validation, a tick prescaler, a configurable hour rollover and an optional lap hold.
- Sits between the centisecond tick generator and the 7-segment display mux.

Parameters:
- HOUR_WRAP, 24, hour modulus. Legal range 1..100. Hours count 0..HOUR_WRAP-1.
- TICK_DIV, 1, number of tick_i pulses per centisecond advance. Must be >= 1. Prescaler width is $clog2(TICK_DIV)+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tick_i  in  1  single-cycle tick pulse
- start_stop_i  in  1  pulse; toggles between run and pause
- clear_i  in  1  pulse; zeroes the counter and returns to IDLE
- dir_i  in  1  0 = count up, 1 = count down; latched on leaving IDLE
- load_i  in  1  pulse; load load_value_i
- load_value_i  in  32  packed BCD, [31:28]=HOUR1 down to [3:0]=CSEG0
- digits_o  out  32  packed BCD display value, same packing as load_value_i
- running_o  out  1  high in RUN
- wrap_o  out  1  one-cycle pulse on up-count rollover
- expired_o  out  1  one-cycle pulse when a down-count reaches zero
- load_err_o  out  1  one-cycle pulse when a load is rejected
- lap_active_o  out  1  high while a lap value is held

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Counter, prescaler and lap register go to 0.
  - State goes to IDLE; direction latch goes to up.
  - All outputs go to 0.
- Control priority per cycle: rst_n > clear_i > load_i > start_stop_i > lap_i. At most one control action is taken per cycle.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
  - IDLE + start_stop_i → RUN. Latch dir_i and clear the prescaler. Exception: dir=1 with the count at all zeros is ignored and the state stays IDLE.
  - RUN + start_stop_i → PAUSE. The prescaler value is kept.
  - PAUSE + start_stop_i → RUN.
  - EXPIRED ignores start_stop_i and load_i.
  - clear_i in any state → IDLE. Counter, prescaler and lap go to 0; lap hold is released.
- Advance:
  - Only in RUN, and only on a cycle with tick_i=1.
  - On each such tick, prescaler == TICK_DIV-1 → advance one centisecond and set prescaler to 0. Otherwise prescaler+1.
  - A tick in the same cycle as a start_stop_i or clear_i is discarded; the state change wins.
- Digit moduli (CSEG0 to HOUR): CSEG0 10, CSEG1 10, SEG0 10, SEG1 6, MIN0 10, MIN1 6.
  - Hours are the two-digit BCD value 0..HOUR_WRAP-1.
  - Each carry/borrow enable is the AND of all lower enables and the terminal condition of the lower digit: digit==max for up, digit==0 for down.
  - Every digit steps by exactly ±1.
- Up wrap: (HOUR_WRAP-1):59:59.99 + advance → 00:00:00.00. wrap_o pulses in that same update cycle, and the state stays RUN.
- Down count:
  - Decrement with borrow. A borrowed digit reloads its max; hours reload HOUR_WRAP-1 only via the borrow chain.
  - Reaching 00:00:00.00 → EXPIRED the same cycle, with a one-cycle expired_o pulse. The counter holds at 0.
- Latency:
  - digits_o, wrap_o and expired_o are registered. An advance at edge N is visible after edge N.
  - running_o reflects the state register.
- Load:
  - Accepted in IDLE or PAUSE only. Prescaler → 0.
  - Rejected if any digit >9, SEG1 >5, MIN1 >5, or hours ≥ HOUR_WRAP. A rejected load leaves the counter unchanged and pulses load_err_o.
  - load_i in RUN or EXPIRED is ignored, with no error pulse.
- Simultaneous events: a rollover and an expiry cannot coincide, because direction is fixed while in RUN.

Optional Feature:
- Macro STOPWATCH_LAP_EN adds input lap_i (1 bit, pulse).
- Defined:
  - In RUN or PAUSE with no lap held: lap_i captures the live count into the lap register and sets lap_active_o=1. digits_o then shows the lap register while counting continues internally.
  - lap_i while a lap is held releases the hold, and digits_o goes live the next cycle.
  - clear_i releases the hold.
- Undefined: the lap_i port is absent, lap_active_o is tied to 0, and digits_o is always live.

Test Plan:
1. HOUR_WRAP=24, TICK_DIV=1: load 23:59:59.98, start up, 2 ticks → digits 23:59:59.99 then 00:00:00.00; wrap_o high exactly one cycle; running_o stays 1.
2. TICK_DIV=4: start up, 10 ticks → CSEG=02, prescaler=2. Pause, 5 ticks → unchanged. Resume, 2 ticks → CSEG=03.
3. Load 00:00:01.00, dir_i=1, start, 100 ticks → 00:00:00.00, state EXPIRED, expired_o one pulse. Further start_stop_i/ticks → unchanged; clear_i → IDLE.
4. In IDLE load 12:61:00.00 → load_err_o pulse, digits unchanged. Load 24:00:00.00 with HOUR_WRAP=24 → rejected. Load 09:30:00.00 → accepted.
5. Same cycle: tick_i=1, start_stop_i=1, clear_i=1 while in RUN → IDLE with counter 0. Then rst_n=0 mid-run → all outputs 0 on the next edge.
6. (STOPWATCH_LAP_EN) Run to 00:00:05.00, pulse lap_i, 50 more ticks → digits_o shows 05.00 with lap_active_o=1. Pulse lap_i again → digits_o 05.50.
